// File: rtl/if_stage.sv
// Instruction fetch stage: single-outstanding ibus fetch, one-entry hold buffer and the IF/ID register.
// Optional IF_MISALIGN_CHECK_EN adds if2id_misaligned and traps fetches from a misaligned PC.
module if_stage #(
  parameter logic [31:0] RESET_VECTOR = 32'h0000_0000
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        if_flush,
  input  logic        if2id_stall,
  input  logic [31:0] branch_target,
  output logic        ibus_req,
  output logic [31:0] ibus_addr,
  input  logic        ibus_ready,
  input  logic        ibus_rvalid,
  input  logic [31:0] ibus_rdata,
  output logic        if2id_valid,
  output logic [31:0] if2id_pc,
  output logic [31:0] if2id_instruction
`ifdef IF_MISALIGN_CHECK_EN
  ,
  output logic        if2id_misaligned
`endif
);

  localparam logic [31:0] NOP = 32'h0000_0013;

  typedef enum logic [1:0] {
    IDLE,
    WAIT,
    DROP
  } state_e;

  state_e      state_q, state_d;
  logic [31:0] pc_q, pc_d;
  logic [31:0] req_pc_q, req_pc_d;
  logic        hold_valid_q, hold_valid_d;
  logic [31:0] hold_pc_q, hold_pc_d;
  logic [31:0] hold_instr_q, hold_instr_d;
  logic        if2id_valid_q, if2id_valid_d;
  logic [31:0] if2id_pc_q, if2id_pc_d;
  logic [31:0] if2id_instr_q, if2id_instr_d;

  logic        rsp_keep;
  logic        fetch_ok;
  logic        accept;
  logic [31:0] flush_pc;

`ifdef IF_MISALIGN_CHECK_EN
  logic        mis_q, mis_d;
  logic        trap_sent_q, trap_sent_d;
  logic        pc_misaligned;
  logic        trap_take;

  assign pc_misaligned = (pc_q[1:0] != 2'b00);
  assign trap_take     = (state_q == IDLE) && pc_misaligned && !trap_sent_q;
  assign flush_pc      = branch_target;
  assign fetch_ok      = !if_flush && !if2id_stall && !pc_misaligned &&
                         ((state_q == IDLE) || rsp_keep);
  assign if2id_misaligned = mis_q;
`else
  // Low target bits are masked rather than dropped so the whole port stays in use.
  assign flush_pc = {branch_target[31:2], branch_target[1:0] & 2'b00};
  assign fetch_ok = !if_flush && !if2id_stall && ((state_q == IDLE) || rsp_keep);
`endif

  assign rsp_keep  = (state_q == WAIT) && ibus_rvalid;
  assign ibus_req  = rst_n && fetch_ok;
  assign ibus_addr = pc_q;
  assign accept    = ibus_req && ibus_ready;

  assign if2id_valid       = if2id_valid_q;
  assign if2id_pc          = if2id_pc_q;
  assign if2id_instruction = if2id_instr_q;

  always_comb begin
    state_d       = state_q;
    pc_d          = pc_q;
    req_pc_d      = req_pc_q;
    hold_valid_d  = hold_valid_q;
    hold_pc_d     = hold_pc_q;
    hold_instr_d  = hold_instr_q;
    if2id_valid_d = if2id_valid_q;
    if2id_pc_d    = if2id_pc_q;
    if2id_instr_d = if2id_instr_q;
`ifdef IF_MISALIGN_CHECK_EN
    mis_d         = mis_q;
    trap_sent_d   = trap_sent_q;
`endif

    if (if_flush) begin
      // A flush wins over stall; an in-flight response must still be absorbed via DROP.
      pc_d          = flush_pc;
      if2id_valid_d = 1'b0;
      hold_valid_d  = 1'b0;
`ifdef IF_MISALIGN_CHECK_EN
      mis_d         = 1'b0;
      trap_sent_d   = 1'b0;
`endif
      if (state_q == WAIT) begin
        state_d = ibus_rvalid ? IDLE : DROP;
      end else if (state_q == DROP && ibus_rvalid) begin
        state_d = IDLE;
      end
    end else begin
      if ((state_q == WAIT || state_q == DROP) && ibus_rvalid) begin
        state_d = IDLE;
      end

      if (accept) begin
        pc_d     = pc_q + 32'd4;
        req_pc_d = pc_q;
        state_d  = WAIT;
      end

      if (rsp_keep && if2id_stall) begin
        hold_valid_d = 1'b1;
        hold_pc_d    = req_pc_q;
        hold_instr_d = ibus_rdata;
      end

      if (!if2id_stall) begin
        if (hold_valid_q) begin
          if2id_valid_d = 1'b1;
          if2id_pc_d    = hold_pc_q;
          if2id_instr_d = hold_instr_q;
          hold_valid_d  = 1'b0;
`ifdef IF_MISALIGN_CHECK_EN
          mis_d         = 1'b0;
`endif
        end else if (rsp_keep) begin
          if2id_valid_d = 1'b1;
          if2id_pc_d    = req_pc_q;
          if2id_instr_d = ibus_rdata;
`ifdef IF_MISALIGN_CHECK_EN
          mis_d         = 1'b0;
        end else if (trap_take) begin
          // Present the bad PC once as a NOP, then sit in IDLE until redirected.
          if2id_valid_d = 1'b1;
          if2id_pc_d    = pc_q;
          if2id_instr_d = NOP;
          mis_d         = 1'b1;
          trap_sent_d   = 1'b1;
`endif
        end else begin
          if2id_valid_d = 1'b0;
`ifdef IF_MISALIGN_CHECK_EN
          mis_d         = 1'b0;
`endif
        end
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q       <= IDLE;
      pc_q          <= RESET_VECTOR;
      req_pc_q      <= '0;
      hold_valid_q  <= 1'b0;
      hold_pc_q     <= '0;
      hold_instr_q  <= NOP;
      if2id_valid_q <= 1'b0;
      if2id_pc_q    <= '0;
      if2id_instr_q <= NOP;
`ifdef IF_MISALIGN_CHECK_EN
      mis_q         <= 1'b0;
      trap_sent_q   <= 1'b0;
`endif
    end else begin
      state_q       <= state_d;
      pc_q          <= pc_d;
      req_pc_q      <= req_pc_d;
      hold_valid_q  <= hold_valid_d;
      hold_pc_q     <= hold_pc_d;
      hold_instr_q  <= hold_instr_d;
      if2id_valid_q <= if2id_valid_d;
      if2id_pc_q    <= if2id_pc_d;
      if2id_instr_q <= if2id_instr_d;
`ifdef IF_MISALIGN_CHECK_EN
      mis_q         <= mis_d;
      trap_sent_q   <= trap_sent_d;
`endif
    end
  end

endmodule
